// File: rtl/inst_fetch.sv
// Instruction fetch front-end: issues in-order bus requests for pcf, tracks them and queues
// returned instructions for decode. Define ADEL_CHECK_EN to trap misaligned fetch PCs.
module inst_fetch #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcf,
  output logic        pc_adv,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_adel
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  // Pending PC queue: PCs of accepted, unanswered requests
  logic [31:0]   pq_pc [DEPTH];
  logic [PW-1:0] pq_wr;
  logic [PW-1:0] pq_rd;
  logic [CW-1:0] pq_cnt;

  // Output buffer towards decode
  logic [31:0]   ob_pc   [DEPTH];
  logic [31:0]   ob_inst [DEPTH];
  logic [PW-1:0] ob_wr;
  logic [PW-1:0] ob_rd;
  logic [CW-1:0] ob_cnt;

  logic [CW-1:0] disc_cnt;

  logic          aligned;
  logic          stall;
  logic          adel_push;
  logic [SW-1:0] used;
  logic          credit_ok;
  logic          req_acc;
  logic          rsp_drop;
  logic          rsp_push;
  logic          consumed;
  logic          ob_push;
  logic          ob_pop;

`ifdef ADEL_CHECK_EN
  logic adel_stall;
  logic ob_adel [DEPTH];

  assign aligned   = (pcf[1:0] == 2'b00);
  assign stall     = adel_stall;
  assign adel_push = ~rst & ~flush & ~adel_stall & ~aligned &
                     (pq_cnt == '0) & (disc_cnt == '0) & (ob_cnt < CW'(DEPTH));
  assign id_adel   = ob_adel[ob_rd];

  // Misaligned fetch parks one error entry and stops fetching until redirected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_stall <= 1'b0;
    end else if (flush) begin
      adel_stall <= 1'b0;
    end else if (adel_push) begin
      adel_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ob_adel[i] <= 1'b0;
      end
    end else if (!flush && ob_push) begin
      ob_adel[ob_wr] <= adel_push;
    end
  end
`else
  assign aligned   = 1'b1;
  assign stall     = 1'b0;
  assign adel_push = 1'b0;
  assign id_adel   = 1'b0;
`endif

  // Credit covers everything that can still land in the buffer, including stale responses
  assign used      = SW'(pq_cnt) + SW'(ob_cnt) + SW'(disc_cnt);
  assign credit_ok = (used < SW'(DEPTH));

  assign inst_req  = ~rst & credit_ok & ~flush & ~stall & aligned;
  assign inst_addr = {pcf[31:2], 2'b00};
  assign req_acc   = inst_req & inst_addr_ok;
  assign pc_adv    = req_acc | adel_push;

  // A response with nothing outstanding is a protocol violation and is ignored
  assign rsp_drop  = inst_data_ok & (disc_cnt != '0);
  assign rsp_push  = inst_data_ok & (disc_cnt == '0) & (pq_cnt != '0);
  assign consumed  = rsp_drop | rsp_push;

  assign id_valid  = (ob_cnt != '0) & ~flush;
  assign ob_pop    = id_valid & id_ready;
  assign ob_push   = rsp_push | adel_push;

  assign id_inst   = ob_inst[ob_rd];
  assign id_pc     = ob_pc[ob_rd];

  always_ff @(posedge clk) begin
    if (req_acc) begin
      pq_pc[pq_wr] <= pcf;
    end
  end

  // On flush, every response still in flight becomes stale, including older stale ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pq_wr    <= '0;
      pq_rd    <= '0;
      pq_cnt   <= '0;
      disc_cnt <= '0;
    end else if (flush) begin
      pq_wr    <= '0;
      pq_rd    <= '0;
      pq_cnt   <= '0;
      disc_cnt <= CW'(disc_cnt + pq_cnt - CW'(consumed));
    end else begin
      if (req_acc) begin
        pq_wr <= pq_wr + PW'(1);
      end
      if (rsp_push) begin
        pq_rd <= pq_rd + PW'(1);
      end
      if (rsp_drop) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
      case ({req_acc, rsp_push})
        2'b10:   pq_cnt <= pq_cnt + CW'(1);
        2'b01:   pq_cnt <= pq_cnt - CW'(1);
        default: pq_cnt <= pq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_wr  <= '0;
      ob_rd  <= '0;
      ob_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ob_pc[i]   <= '0;
        ob_inst[i] <= '0;
      end
    end else if (flush) begin
      ob_wr  <= '0;
      ob_rd  <= '0;
      ob_cnt <= '0;
    end else begin
      if (ob_push) begin
        ob_pc[ob_wr]   <= rsp_push ? pq_pc[pq_rd] : pcf;
        ob_inst[ob_wr] <= rsp_push ? inst_rdata : 32'h0;
        ob_wr          <= ob_wr + PW'(1);
      end
      if (ob_pop) begin
        ob_rd <= ob_rd + PW'(1);
      end
      case ({ob_push, ob_pop})
        2'b10:   ob_cnt <= ob_cnt + CW'(1);
        2'b01:   ob_cnt <= ob_cnt - CW'(1);
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch: a queue-level model of fetch, bus memory and
// PC register predicts bus requests and the decode stream (ADEL_CHECK_EN path when defined).
module tb_inst_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
`ifdef ADEL_CHECK_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        pc_adv;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_adel;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pcf(pcf), .pc_adv(pc_adv), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata),
    .inst_data_ok(inst_data_ok), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stale;
    int          due;
  } fly_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  fly_t        fly[$];
  ent_t        expq[$];
  logic [31:0] pc_reg;
  logic        adel_stall;
  int          cyc;
  int          errors;
  int          checks;

  int unsigned p_ok, p_ready, p_flush, lat_max, p_rsp, p_spur;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_knobs(input int unsigned ok, input int unsigned rdy, input int unsigned fl,
                           input int unsigned lat, input int unsigned rsp, input int unsigned sp);
    p_ok = ok; p_ready = rdy; p_flush = fl; lat_max = lat; p_rsp = rsp; p_spur = sp;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    fly.delete();
    expq.delete();
    adel_stall   = 1'b0;
    pc_reg       = RESET_PC;
    pcf          = RESET_PC;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    flush        = 1'b0;
    id_ready     = 1'b1;
    #1;
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_pc_adv", 32'(pc_adv), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_adel", 32'(id_adel), 32'd0);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
    inst_addr_ok = 1'b0;
    rst = 1'b0;
  endtask

  // One bus/decode cycle: drive at negedge, check requests, advance the model at posedge
  task automatic step();
    logic        exp_req;
    logic        exp_adel;
    logic        al;
    logic        dok;
    logic [31:0] pc_next;
    logic [31:0] tgt;
    int          used;
    fly_t        f;
    @(negedge clk);
    cyc++;
    pcf          = pc_reg;
    inst_addr_ok = ($urandom_range(99) < p_ok);
    id_ready     = ($urandom_range(99) < p_ready);
    flush        = ($urandom_range(99) < p_flush);
    dok = 1'b0;
    if (fly.size() != 0) begin
      if (fly[0].due <= cyc && $urandom_range(99) < p_rsp) dok = 1'b1;
    end else if ($urandom_range(99) < p_spur) begin
      dok = 1'b1;
    end
    inst_data_ok = dok;
    inst_rdata   = (dok && fly.size() != 0) ? mem_word({fly[0].pc[31:2], 2'b00}) : $urandom;
    #1;
    used     = fly.size() + expq.size();
    al       = !ADEL || (pcf[1:0] == 2'b00);
    exp_req  = (used < DEPTH) && !flush && !adel_stall && al;
    exp_adel = ADEL && !al && fly.size() == 0 && expq.size() < DEPTH && !flush && !adel_stall;
    check("inst_req", 32'(inst_req), 32'(exp_req));
    if (exp_req) check("inst_addr", inst_addr, {pcf[31:2], 2'b00});
    check("pc_adv", 32'(pc_adv), 32'((exp_req && inst_addr_ok) || exp_adel));
    @(posedge clk);
    pc_next = pc_reg;
    if (dok && fly.size() != 0) begin
      f = fly.pop_front();
      if (!f.stale) expq.push_back('{pc: f.pc, inst: inst_rdata, adel: 1'b0});
    end
    if (exp_req && inst_addr_ok) begin
      fly.push_back('{pc: pcf, stale: 1'b0, due: cyc + int'($urandom_range(lat_max, 1))});
      pc_next = pcf + 32'd4;
    end
    if (exp_adel) begin
      expq.push_back('{pc: pcf, inst: 32'h0, adel: 1'b1});
      adel_stall = 1'b1;
      pc_next    = pcf + 32'd4;
    end
    if (flush) begin
      foreach (fly[i]) fly[i].stale = 1'b1;
      expq.delete();
      adel_stall = 1'b0;
      tgt        = $urandom;
      tgt[1:0]   = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
      pc_next    = tgt;
    end
    pc_reg = pc_next;
  endtask

  // Decode-side monitor: compares every transfer against the head of the expected stream
  initial begin : monitor
    ent_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      #2;
      exp_v = (expq.size() != 0) && !flush && !rst;
      check("id_valid", 32'(id_valid), 32'(exp_v));
      if (exp_v && id_ready) begin
        e = expq.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_inst", id_inst, e.inst);
        check("id_adel", 32'(id_adel), 32'(e.adel));
      end
    end
  end

  initial begin : stimulus
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; pcf = RESET_PC; inst_addr_ok = 1'b0; inst_rdata = '0;
    inst_data_ok = 1'b0; flush = 1'b0; id_ready = 1'b0;
    adel_stall = 1'b0; pc_reg = RESET_PC;
    set_knobs(100, 100, 0, 1, 100, 0);
    do_reset(2);
    repeat (30) step();
    set_knobs(100, 0, 0, 1, 100, 0);
    repeat (20) step();
    set_knobs(25, 100, 0, 3, 100, 0);
    repeat (40) step();
    set_knobs(100, 60, 15, 3, 70, 0);
    repeat (60) step();
    do_reset(1);
    set_knobs(100, 80, 5, 2, 80, 30);
    repeat (30) step();
    set_knobs(70, 70, 8, 4, 60, 10);
    repeat (700) step();
    set_knobs(100, 100, 0, 1, 100, 0);
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
